// File: rtl/dram_writer_buf_if.sv
// ----------------------------------------------------------------------------
// dram_writer_buf_if
//
// AXI3 HP write-channel bundle between the DRAM frame writer and the HP port.
//
// Signals:
//   AW channel : M2S_AXI_AWVALID/AWREADY, AWADDR[31:0], AWBURST[1:0],
//                AWLEN[3:0], AWSIZE[1:0]
//   W channel  : M2S_AXI_WVALID/WREADY, WDATA[63:0], WSTRB[7:0], WLAST
//   B channel  : M2S_AXI_BVALID/BREADY, BRESP[1:0]
//
// Modports:
//   master : the writer (drives AW/W, accepts B)
//   slave  : the memory-side port model / interconnect
// ----------------------------------------------------------------------------
interface dram_writer_buf_if;
    logic        M2S_AXI_AWVALID;
    logic        M2S_AXI_AWREADY;
    logic [31:0] M2S_AXI_AWADDR;
    logic [1:0]  M2S_AXI_AWBURST;
    logic [3:0]  M2S_AXI_AWLEN;
    logic [1:0]  M2S_AXI_AWSIZE;
    logic        M2S_AXI_WVALID;
    logic        M2S_AXI_WREADY;
    logic [63:0] M2S_AXI_WDATA;
    logic [7:0]  M2S_AXI_WSTRB;
    logic        M2S_AXI_WLAST;
    logic        M2S_AXI_BVALID;
    logic        M2S_AXI_BREADY;
    logic [1:0]  M2S_AXI_BRESP;

    modport master (
        output M2S_AXI_AWVALID, M2S_AXI_AWADDR, M2S_AXI_AWBURST, M2S_AXI_AWLEN,
               M2S_AXI_AWSIZE, M2S_AXI_WVALID, M2S_AXI_WDATA, M2S_AXI_WSTRB,
               M2S_AXI_WLAST, M2S_AXI_BREADY,
        input  M2S_AXI_AWREADY, M2S_AXI_WREADY, M2S_AXI_BVALID, M2S_AXI_BRESP
    );

    modport slave (
        input  M2S_AXI_AWVALID, M2S_AXI_AWADDR, M2S_AXI_AWBURST, M2S_AXI_AWLEN,
               M2S_AXI_AWSIZE, M2S_AXI_WVALID, M2S_AXI_WDATA, M2S_AXI_WSTRB,
               M2S_AXI_WLAST, M2S_AXI_BREADY,
        output M2S_AXI_AWREADY, M2S_AXI_WREADY, M2S_AXI_BVALID, M2S_AXI_BRESP
    );
endinterface

// File: rtl/dram_writer_buf.sv
// ----------------------------------------------------------------------------
// dram_writer_buf
//
// Buffers a 64-bit valid/ready pixel stream in a FIFO and writes whole frames
// to DRAM over an AXI3 HP write port using fixed 16-beat, 128-byte INCR
// bursts, one burst outstanding at a time. Each frame's base address and size
// are taken from a valid/ready config handshake.
//
// Parameters:
//   FIFO_AW      : FIFO address width (depth = 2**FIFO_AW 64-bit words)
//   BURST_THRESH : FIFO occupancy needed before an AW is issued (>= 16)
//
// Ports:
//   fclk, rst        : clock; synchronous active-high reset
//   M2S_AXI_ACLK     : copy of fclk for the HP port
//   axi              : AXI3 write channels (dram_writer_buf_if.master)
//   wr_frame_valid/ready, wr_FRAME_BYTES, wr_BUF_ADDR : per-frame config
//   din_valid/ready, din : pixel stream in
//   debug_wstate     : current write state
//   resp_err         : sticky error on non-OKAY BRESP
//
// Optional feature (macro DRAM_WRITER_BRESP_CHECK_EN):
//   defined   - resp_err latches any non-OKAY BRESP; a 16-bit saturating
//               error counter is kept alongside it.
//   undefined - resp_err is tied low and BRESP is ignored.
// ----------------------------------------------------------------------------
module dram_writer_buf #(
    parameter int FIFO_AW      = 9,
    parameter int BURST_THRESH = 16
) (
    input  logic                fclk,
    input  logic                rst,
    output logic                M2S_AXI_ACLK,
    dram_writer_buf_if.master   axi,
    input  logic                wr_frame_valid,
    output logic                wr_frame_ready,
    input  logic [31:0]         wr_FRAME_BYTES,
    input  logic [31:0]         wr_BUF_ADDR,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [63:0]         din,
    output logic [1:0]          debug_wstate,
    output logic                resp_err
);
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wstate_t;

    localparam int               DEPTH  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] THRESH = BURST_THRESH[FIFO_AW:0];

    // ------------------------------------------------------------------
    // Stream FIFO
    // ------------------------------------------------------------------
    logic [63:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push;
    logic               pop;
    logic               wvalid;

    assign din_ready = (count != FULL);
    assign push      = din_valid && din_ready;
    assign pop       = wvalid && axi.M2S_AXI_WREADY;

    // NOTE: the storage array has no reset; only the pointers and count define
    // what is valid, and leaving the RAM unreset lets it map onto block RAM.
    always_ff @(posedge fclk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge fclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    wstate_t     state, state_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [24:0] bursts_q, bursts_d;
    logic [3:0]  beat_q, beat_d;
    logic        frame_ready_q, frame_ready_d;

    always_ff @(posedge fclk) begin
        if (rst) begin
            state         <= W_IDLE;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            bursts_q      <= '0;
            beat_q        <= '0;
            frame_ready_q <= 1'b0;
        end else begin
            state         <= state_d;
            awvalid_q     <= awvalid_d;
            awaddr_q      <= awaddr_d;
            bursts_q      <= bursts_d;
            beat_q        <= beat_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state;
        awvalid_d     = awvalid_q;
        awaddr_d      = awaddr_q;
        bursts_d      = bursts_q;
        beat_d        = beat_q;
        frame_ready_d = 1'b0;      // low on the first cycle back in W_IDLE

        unique case (state)
            W_IDLE: begin
                frame_ready_d = 1'b1;
                if (wr_frame_valid && frame_ready_q) begin
                    frame_ready_d = 1'b0;
                    awaddr_d      = wr_BUF_ADDR;
                    bursts_d      = wr_FRAME_BYTES[31:7];
                    // A frame shorter than one burst is accepted and dropped.
                    if (wr_FRAME_BYTES[31:7] != '0) state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (!awvalid_q) begin
                    // Wait until a whole burst is buffered so W never starves.
                    if (count >= THRESH) awvalid_d = 1'b1;
                end else if (axi.M2S_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.M2S_AXI_WREADY) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == 4'd15) state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.M2S_AXI_BVALID) begin
                    awaddr_d = awaddr_q + 32'd128;
                    bursts_d = bursts_q - 1'b1;
                    state_d  = (bursts_q == 25'd1) ? W_IDLE : W_ADDR;
                end
            end
        endcase
    end

    assign wvalid = (state == W_DATA);

    assign M2S_AXI_ACLK        = fclk;
    assign axi.M2S_AXI_AWVALID = awvalid_q;
    assign axi.M2S_AXI_AWADDR  = awaddr_q;
    assign axi.M2S_AXI_AWBURST = 2'b01;
    assign axi.M2S_AXI_AWLEN   = 4'b1111;
    assign axi.M2S_AXI_AWSIZE  = 2'b11;
    assign axi.M2S_AXI_WVALID  = wvalid;
    assign axi.M2S_AXI_WDATA   = mem[rd_ptr];
    assign axi.M2S_AXI_WSTRB   = 8'hFF;
    assign axi.M2S_AXI_WLAST   = wvalid && (beat_q == 4'd15);
    assign axi.M2S_AXI_BREADY  = (state == W_RESP);
    assign wr_frame_ready      = frame_ready_q;
    assign debug_wstate        = state;

    // ------------------------------------------------------------------
    // Write-response error tracking
    // ------------------------------------------------------------------
`ifdef DRAM_WRITER_BRESP_CHECK_EN
    logic        err_flag;
    logic [15:0] err_cnt;

    always_ff @(posedge fclk) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (axi.M2S_AXI_BVALID && (axi.M2S_AXI_BRESP != 2'b00)) begin
            err_flag <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign resp_err = err_flag;

    logic unused_ok;
    assign unused_ok = &{1'b0, wr_FRAME_BYTES[6:0], err_cnt};
`else
    assign resp_err = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, wr_FRAME_BYTES[6:0], axi.M2S_AXI_BRESP};
`endif

endmodule

// File: tb/tb_dram_writer_buf.sv
// ----------------------------------------------------------------------------
// tb_dram_writer_buf
//
// Scoreboard bench for dram_writer_buf. The stimulus thread arms frames and
// pushes stream words, queueing the expected AW addresses and W data as it
// goes. A separate slave process models the HP port (AWREADY delay, WREADY
// pattern, B responses) and pops/compares every AW and W handshake it sees.
// Inputs are driven 1 ns after the rising edge; handshakes are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dram_writer_buf;

`ifdef DRAM_WRITER_BRESP_CHECK_EN
    localparam logic EXP_RESP_ERR = 1'b1;
`else
    localparam logic EXP_RESP_ERR = 1'b0;
`endif

    logic        fclk = 1'b0;
    logic        rst;
    logic        aclk;
    logic        wr_frame_valid;
    logic        wr_frame_ready;
    logic [31:0] wr_FRAME_BYTES;
    logic [31:0] wr_BUF_ADDR;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din;
    logic [1:0]  debug_wstate;
    logic        resp_err;

    always #5 fclk = ~fclk;

    dram_writer_buf_if bus ();

    dram_writer_buf dut (
        .fclk           (fclk),
        .rst            (rst),
        .M2S_AXI_ACLK   (aclk),
        .axi            (bus),
        .wr_frame_valid (wr_frame_valid),
        .wr_frame_ready (wr_frame_ready),
        .wr_FRAME_BYTES (wr_FRAME_BYTES),
        .wr_BUF_ADDR    (wr_BUF_ADDR),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .din            (din),
        .debug_wstate   (debug_wstate),
        .resp_err       (resp_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_aw [$];
    logic [63:0] exp_w  [$];

    // Slave-model state and knobs (knobs written by stimulus only).
    int total_words   = 0;
    int b_total       = 0;
    int beat_in_burst = 0;
    int aw_delay      = 0;
    int err_at        = -1;
    bit w_toggle      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // HP-port slave model + monitor
    // ------------------------------------------------------------------
    initial begin : axi_slave
        bit          wlast_seen;
        bit          b_seen;
        bit          in_rst;
        bit          aw_hold;
        logic [31:0] held_addr;
        int          aw_wait;
        aw_hold   = 1'b0;
        held_addr = '0;
        aw_wait   = 0;
        bus.M2S_AXI_AWREADY = 1'b0;
        bus.M2S_AXI_WREADY  = 1'b0;
        bus.M2S_AXI_BVALID  = 1'b0;
        bus.M2S_AXI_BRESP   = 2'b00;
        forever begin
            @(negedge fclk);
            in_rst     = rst;
            wlast_seen = 1'b0;
            b_seen     = 1'b0;
            if (rst) begin
                beat_in_burst = 0;
                aw_hold       = 1'b0;
            end else begin
                if (bus.M2S_AXI_AWVALID) begin
                    if (aw_hold) check("awaddr_stable", bus.M2S_AXI_AWADDR, held_addr);
                    held_addr = bus.M2S_AXI_AWADDR;
                    aw_hold   = !bus.M2S_AXI_AWREADY;
                end else begin
                    aw_hold = 1'b0;
                end
                if (bus.M2S_AXI_AWVALID && bus.M2S_AXI_AWREADY) begin
                    check("aw_expected", exp_aw.size() != 0, 1);
                    if (exp_aw.size() != 0) check("awaddr", bus.M2S_AXI_AWADDR, exp_aw.pop_front());
                    check("aw_burst_len_size",
                          {bus.M2S_AXI_AWBURST, bus.M2S_AXI_AWLEN, bus.M2S_AXI_AWSIZE},
                          {2'b01, 4'b1111, 2'b11});
                end
                if (bus.M2S_AXI_WVALID && bus.M2S_AXI_WREADY) begin
                    check("w_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0) check("wdata", bus.M2S_AXI_WDATA, exp_w.pop_front());
                    check("wlast", bus.M2S_AXI_WLAST, beat_in_burst == 15);
                    check("wstrb", bus.M2S_AXI_WSTRB, 8'hFF);
                    total_words++;
                    beat_in_burst = (beat_in_burst == 15) ? 0 : beat_in_burst + 1;
                    wlast_seen    = bus.M2S_AXI_WLAST;
                end
                if (bus.M2S_AXI_BVALID && bus.M2S_AXI_BREADY) begin
                    b_seen = 1'b1;
                    b_total++;
                end
            end

            @(posedge fclk);
            #1;
            if (in_rst) begin
                bus.M2S_AXI_AWREADY = 1'b0;
                bus.M2S_AXI_BVALID  = 1'b0;
                bus.M2S_AXI_WREADY  = 1'b1;
                aw_wait             = 0;
            end else begin
                if (bus.M2S_AXI_AWREADY) begin
                    bus.M2S_AXI_AWREADY = 1'b0;
                    aw_wait             = 0;
                end else if (bus.M2S_AXI_AWVALID) begin
                    if (aw_wait >= aw_delay) bus.M2S_AXI_AWREADY = 1'b1;
                    else aw_wait++;
                end
                bus.M2S_AXI_WREADY = w_toggle ? ~bus.M2S_AXI_WREADY : 1'b1;
                if (b_seen) bus.M2S_AXI_BVALID = 1'b0;
                if (wlast_seen) begin
                    bus.M2S_AXI_BVALID = 1'b1;
                    bus.M2S_AXI_BRESP  = (b_total == err_at) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic arm(input logic [31:0] base, input logic [31:0] bytes);
        bit ok;
        int nb;
        nb = int'(bytes >> 7);
        for (int i = 0; i < nb; i++) exp_aw.push_back(base + 32'(i) * 32'd128);
        wr_BUF_ADDR    = base;
        wr_FRAME_BYTES = bytes;
        wr_frame_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge fclk);
            ok = wr_frame_ready;
            tick();
        end
        wr_frame_valid = 1'b0;
        check("arm_accepted", ok, 1);
    endtask

    task automatic push_word(input logic [63:0] d);
        bit ok;
        din       = d;
        din_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge fclk);
            if (din_ready) begin
                ok = 1'b1;
                exp_w.push_back(d);
            end
            tick();
        end
        if (!ok) check("push_accepted", ok, 1);
    endtask

    task automatic push_run(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) push_word(base + 64'(i));
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (debug_wstate == 2'd0) && wr_frame_ready;
        end
        check(name, done, 1);
        check("aw_queue_drained", exp_aw.size(), 0);
        check("w_queue_drained", exp_w.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stim
        int w0;
        int b0;
        int acc;
        bit seen;

        rst            = 1'b1;
        wr_frame_valid = 1'b0;
        wr_FRAME_BYTES = '0;
        wr_BUF_ADDR    = '0;
        din_valid      = 1'b0;
        din            = '0;

        // Reset state
        repeat (4) tick();
        check("rst_awvalid", bus.M2S_AXI_AWVALID, 0);
        check("rst_wvalid", bus.M2S_AXI_WVALID, 0);
        check("rst_bready", bus.M2S_AXI_BREADY, 0);
        check("rst_wlast", bus.M2S_AXI_WLAST, 0);
        check("rst_awaddr", bus.M2S_AXI_AWADDR, 0);
        check("rst_frame_ready", wr_frame_ready, 0);
        check("rst_state", debug_wstate, 0);
        check("rst_din_ready", din_ready, 1);
        check("rst_resp_err", resp_err, 0);
        check("aclk_follows_fclk", aclk, fclk);
        rst = 1'b0;
        tick();
        check("ready_after_rst", wr_frame_ready, 1);

        // Single-burst frame, words 0..15
        w0 = total_words;
        b0 = b_total;
        arm(32'h1000_0000, 32'd128);
        push_run(64'd0, 16);
        wait_idle("t1_done", 300);
        check("t1_words", total_words - w0, 16);
        check("t1_b_count", b_total - b0, 1);

        // Four bursts with AWREADY delay and toggling WREADY
        aw_delay = 5;
        w_toggle = 1'b1;
        w0 = total_words;
        arm(32'h2000_0000, 32'd512);
        push_run(64'h2000, 64);
        wait_idle("t2_done", 1000);
        check("t2_words", total_words - w0, 64);
        aw_delay = 0;
        w_toggle = 1'b0;

        // FIFO full with no frame armed, then drain with a 4096-byte frame
        acc       = 0;
        din_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            din = 64'h3000_0000 + 64'(acc);
            @(negedge fclk);
            if (din_ready) begin
                exp_w.push_back(din);
                acc++;
            end
            tick();
        end
        din_valid = 1'b0;
        check("t3_accepted", acc, 512);
        check("t3_din_ready_full", din_ready, 0);
        check("t3_still_idle", debug_wstate, 0);
        w0 = total_words;
        arm(32'h3000_0000, 32'd4096);
        wait_idle("t3_done", 4000);
        check("t3_words", total_words - w0, 512);
        check("t3_din_ready_after", din_ready, 1);

        // Sub-burst frame: no AXI traffic, ready comes back within 2 cycles
        arm(32'h4000_0000, 32'd64);
        check("t4_state", debug_wstate, 0);
        check("t4_ready_drop", wr_frame_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = wr_frame_ready;
        end
        check("t4_ready_back", seen, 1);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_awvalid", bus.M2S_AXI_AWVALID, 0);
            tick();
        end

        // Reset during beat 7, then a clean 128-byte frame
        arm(32'h5000_0000, 32'd128);
        push_run(64'h5000, 16);
        for (int i = 0; i < 200 && beat_in_burst != 7; i++) tick();
        check("t5_reach_beat7", beat_in_burst, 7);
        rst = 1'b1;
        tick();
        exp_w.delete();
        exp_aw.delete();
        check("t5_wvalid", bus.M2S_AXI_WVALID, 0);
        check("t5_state", debug_wstate, 0);
        check("t5_fifo_empty", 64'(dut.count), 0);
        check("t5_awvalid", bus.M2S_AXI_AWVALID, 0);
        rst = 1'b0;
        tick();
        check("t5_ready", wr_frame_ready, 1);
        w0 = total_words;
        arm(32'h6000_0000, 32'd128);
        push_run(64'h6000, 16);
        wait_idle("t5_done", 300);
        check("t5_words", total_words - w0, 16);

        // SLVERR on burst 2 of 3
        check("t6_resp_err_before", resp_err, 0);
        err_at = b_total + 1;
        arm(32'h7000_0000, 32'd384);
        push_run(64'h7000, 48);
        wait_idle("t6_done", 800);
        check("t6_resp_err", resp_err, EXP_RESP_ERR);
        repeat (5) tick();
        check("t6_resp_err_sticky", resp_err, EXP_RESP_ERR);
        err_at = -1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dram_writer_buf.md
Name: dram_writer_buf

Overview:
- Write-direction counterpart of the DRAM frame reader.
- Accepts a 64-bit valid/ready pixel stream into an internal FIFO and writes whole frames to DRAM over an AXI3 HP write port.
- Writes use fixed 16-beat, 128-byte INCR bursts with one burst outstanding at a time.
- Frame base address and size arrive per frame on a valid/ready config handshake from the control block.

Parameters:
- FIFO_AW, 9: FIFO address width; depth = 2^FIFO_AW words of 64 bits (512).
- BURST_THRESH, 16: FIFO occupancy in words required before an AW is issued; must be >= 16.

Ports:
- fclk  in  1  sole clock; also driven out on M2S_AXI_ACLK.
- rst  in  1  reset, synchronous, active-high.
- M2S_AXI_ACLK  out  1  equals fclk.
- M2S_AXI_AWVALID  out  1  write address valid.
- M2S_AXI_AWREADY  in  1  write address ready.
- M2S_AXI_AWADDR  out  32  burst byte address.
- M2S_AXI_AWBURST  out  2  constant 2'b01 (INCR).
- M2S_AXI_AWLEN  out  4  constant 4'b1111.
- M2S_AXI_AWSIZE  out  2  constant 2'b11.
- M2S_AXI_WVALID  out  1  write data valid.
- M2S_AXI_WREADY  in  1  write data ready.
- M2S_AXI_WDATA  out  64  write data = FIFO head.
- M2S_AXI_WSTRB  out  8  constant 8'hFF.
- M2S_AXI_WLAST  out  1  high on beat 16 of each burst.
- M2S_AXI_BVALID  in  1  write response valid.
- M2S_AXI_BREADY  out  1  write response ready.
- M2S_AXI_BRESP  in  2  write response code.
- wr_frame_valid  in  1  config valid.
- wr_frame_ready  out  1  config ready; high only in W_IDLE.
- wr_FRAME_BYTES  in  32  frame size in bytes; must be a multiple of 128.
- wr_BUF_ADDR  in  32  frame base address; must be 128-byte aligned.
- din_valid  in  1  stream valid.
- din_ready  out  1  stream ready; equals !fifo_full.
- din  in  64  stream data.
- debug_wstate  out  2  current state.
- resp_err  out  1  see Optional Feature.

Behaviour:
- Reset values: all AXI valid outputs 0, BREADY 0, WLAST 0, AWADDR 0, wr_frame_ready 0, debug_wstate W_IDLE, FIFO empty, resp_err 0.
- Reset is synchronous; asserting it mid-burst drops the burst immediately. The interconnect is reset together with this block.
- FIFO: push when din_valid && din_ready; pop when WVALID && WREADY. Push and pop in the same cycle leave the count unchanged. Count width is FIFO_AW+1. din_ready = (count != 2^FIFO_AW).
- The stream is accepted in every state, including W_IDLE, so data may be buffered before a frame is armed.
- States: W_IDLE=0, W_ADDR=1, W_DATA=2, W_RESP=3.
- W_IDLE:
  - wr_frame_ready is registered high one cycle after entering W_IDLE.
  - On wr_frame_valid && wr_frame_ready: latch AWADDR <= wr_BUF_ADDR and bursts_left <= wr_FRAME_BYTES[31:7]; drop wr_frame_ready next cycle.
  - If wr_FRAME_BYTES[31:7]==0, stay in W_IDLE with no AXI traffic and re-raise ready on the following cycle. Otherwise go to W_ADDR.
  - wr_FRAME_BYTES[6:0] is ignored.
- W_ADDR:
  - When count >= BURST_THRESH and AWVALID==0, assert AWVALID.
  - Hold AWVALID and AWADDR stable until AWREADY is sampled high.
  - Then deassert AWVALID, clear beat counter, go to W_DATA.
- W_DATA:
  - WVALID = 1 combinationally in this state. The FIFO holds at least 16 words, so there is no underflow.
  - Beat counter 0..15 advances on each WREADY; WLAST = (beat==15).
  - On the WLAST handshake go to W_RESP.
- W_RESP:
  - BREADY = 1.
  - On BVALID: AWADDR <= AWADDR + 128 (32-bit wrap allowed) and bursts_left decrements.
  - If bursts_left was 1, go to W_IDLE (frame done). Otherwise go to W_ADDR.
- Latency: the first AWVALID appears 1 cycle after entering W_ADDR with the FIFO at or above threshold. W beats run back-to-back when WREADY is held high.
- wr_frame_valid asserted outside W_IDLE is ignored until ready rises.

Optional Feature:
- Macro: DRAM_WRITER_BRESP_CHECK_EN.
- Defined:
  - resp_err is a sticky flag, set on any BVALID with BRESP != 2'b00; cleared only by rst.
  - An internal 16-bit saturating error counter is kept alongside it.
- Undefined:
  - resp_err is tied 0 and BRESP is unused.
  - No counter logic is generated.

Test Plan:
- Single-burst frame: rst 4 cycles; frame BUF_ADDR=0x1000_0000, FRAME_BYTES=128; push 16 words 0..15 -> one AW at 0x1000_0000, 16 W beats with WLAST on word 15, BREADY on B, then wr_frame_ready=1.
- Multi-burst with backpressure: FRAME_BYTES=512, AWREADY delayed 5 cycles, WREADY toggling every cycle -> 4 bursts at base+0/128/256/384; AWADDR stable while AWVALID=1; 64 words in order.
- FIFO full: frame not armed, push 600 words -> din_ready falls after word 512. Then arm FRAME_BYTES=4096 -> drain, and total words written to DRAM equals 512.
- Zero-size frame: FRAME_BYTES=64 -> no AWVALID ever; wr_frame_ready returns high within 2 cycles.
- Reset mid-burst: assert rst at beat 7 -> next cycle WVALID=0, FIFO empty, state W_IDLE; a subsequent 128-byte frame completes correctly.
- With DRAM_WRITER_BRESP_CHECK_EN: BRESP=2'b10 on burst 2 of 3 -> resp_err=1 and remains set after frame end; undefined build -> resp_err=0.
